// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake, Z/N/C/V/ERR flags and an
// iterative shift-add multiplier (one multiplier bit per cycle).
module alu_seq #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [4:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_result,
    output logic [7:0]       o_flags,
    output logic             o_busy
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Single-cycle ops; returns {flags, result}. Unknown opcodes (incl. MUL) flag ERR.
    function automatic logic [WIDTH+7:0] alu_eval(input logic [4:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH:0]        ext;
        logic signed [WIDTH:0] sext;
        logic [WIDTH-1:0]      r;
        logic                  c, v, err;
        ext  = '0;
        sext = '0;
        r    = '0;
        c    = 1'b0;
        v    = 1'b0;
        err  = 1'b0;
        case (op)
            5'd0: begin
                ext = {1'b0, a} - {1'b0, b};
                r   = ext[WIDTH-1:0];
                c   = ext[WIDTH];
                v   = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            5'd1: r = a & b;
            5'd2: begin
                ext = {1'b0, a} + {1'b0, b};
                r   = ext[WIDTH-1:0];
                c   = ext[WIDTH];
                v   = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            5'd3: r = a | b;
            5'd4: r = a ^ b;
            // Extra guard bit catches the last bit shifted out for any amount.
            5'd5: begin
                ext = {a, 1'b0} >> b;
                r   = ext[WIDTH:1];
                c   = ext[0];
            end
            5'd6: begin
                ext = {1'b0, a} << b;
                r   = ext[WIDTH-1:0];
                c   = ext[WIDTH];
            end
            5'd7: begin
                sext = $signed({a, 1'b0}) >>> b;
                r    = sext[WIDTH:1];
                c    = sext[0];
            end
            5'd8: r = ~a;
            default: err = 1'b1;
        endcase
        return {3'b000, err, v, c, r[WIDTH-1], (r == '0), r};
    endfunction

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [7:0]         flags_q, flags_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               ready_s, accept_s;
    logic [WIDTH+7:0]   eval_s;

    assign ready_s  = (state_q == S_IDLE) || ((state_q == S_DONE) && i_out_ready);
    assign accept_s = i_valid && ready_s;
    assign o_ready  = ready_s;
    assign o_valid  = valid_q;
    assign o_result = result_q;
    assign o_flags  = flags_q;
    assign o_busy   = busy_q;

    // Next-state logic for the handshake FSM, result registers and multiplier.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        eval_s   = alu_eval(i_op, i_a, i_b);
        case (state_q)
            S_IDLE, S_DONE: begin
                if ((state_q == S_DONE) && i_out_ready) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
                if (accept_s) begin
                    if (MUL_EN && (i_op == 5'd9)) begin
                        state_d  = S_MUL;
                        valid_d  = 1'b0;
                        busy_d   = 1'b1;
                        mcand_d  = {{WIDTH{1'b0}}, i_a};
                        mplier_d = i_b;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end else begin
                        state_d  = S_DONE;
                        valid_d  = 1'b1;
                        result_d = eval_s[WIDTH-1:0];
                        flags_d  = eval_s[WIDTH+7:WIDTH];
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
            // WIDTH iterations, then one cycle to publish result and flags.
            S_MUL: begin
                if (cnt_q == CW'(WIDTH)) begin
                    state_d  = S_DONE;
                    valid_d  = 1'b1;
                    busy_d   = 1'b0;
                    result_d = acc_q[WIDTH-1:0];
                    flags_d  = {5'b00000, (acc_q[2*WIDTH-1:WIDTH] != '0),
                                acc_q[WIDTH-1], (acc_q[WIDTH-1:0] == '0)};
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end else begin
                        acc_d = acc_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                    busy_d   = (cnt_q != CW'(WIDTH - 1));
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight multiply.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            flags_q  <= 8'h00;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the dcpu combinational ALU.
- Adds a valid/ready handshake, registered result and flags (Z/N/C/V/ERR), bit-accurate shifts with carry-out, and an iterative shift-add multiplier.
- Sits between the dcpu decode stage and writeback. Decode issues one operation at a time; writeback consumes the result with backpressure.

Parameters:
- WIDTH, 32: datapath width. Power of two, at least 8.
- MUL_EN, 1: 1 enables MUL (op 9). 0 makes op 9 illegal.

Ports:
- i_clk  in  1: rising-edge clock.
- i_reset  in  1: asynchronous, active-low reset.
- i_valid  in  1: operation request.
- o_ready  out  1: block can accept a request this cycle.
- i_op  in  5: opcode.
- i_a  in  WIDTH: operand A.
- i_b  in  WIDTH: operand B; also the shift amount.
- o_valid  out  1: o_result/o_flags hold a completed result.
- i_out_ready  in  1: consumer accepts the result.
- o_result  out  WIDTH: registered result.
- o_flags  out  8: [0]Z [1]N [2]C [3]V [4]ERR [7:5]=0.
- o_busy  out  1: high while in MUL state.

Behaviour:
- Reset (i_reset=0, asynchronous): state=IDLE, o_valid=0, o_result=0, o_flags=0, o_busy=0; any in-flight MUL is discarded. Release is synchronous to i_clk.
- Accept: i_valid & o_ready at a rising edge. Operands and op are captured at that edge; inputs are don't-care otherwise.
- o_ready = (state==IDLE) | (state==DONE & i_out_ready). This allows back-to-back issue.
- States:
  - IDLE: accept of a non-MUL op -> DONE. Accept of MUL -> MUL.
  - MUL: iterate WIDTH cycles (counter 0..WIDTH-1, one multiplier bit per cycle), then -> DONE.
  - DONE: o_valid=1. If i_out_ready & new accept -> DONE (non-MUL) or MUL. If i_out_ready & no accept -> IDLE. If i_out_ready=0, hold o_result/o_flags unchanged.
- Latency: non-MUL ops give o_valid on the cycle after accept (1 cycle). MUL gives o_valid WIDTH+1 cycles after accept.
- Opcodes:
  - 0 SUB: A-B.
  - 1 AND.
  - 2 ADD: A+B.
  - 3 OR.
  - 4 XOR.
  - 5 LSR: A>>B, logical.
  - 6 LSL: A<<B.
  - 7 ASR: A>>>B, arithmetic.
  - 8 NOT: ~A.
  - 9 MUL: low WIDTH bits of unsigned A*B.
  - 10..31 (and 9 when MUL_EN=0): illegal. Result 0, ERR=1, Z=1, other flags 0; completes in 1 cycle.
- Z = (result==0). N = result[WIDTH-1]. ERR=0 for legal ops.
- C flag:
  - ADD: carry out.
  - SUB: borrow, i.e. 1 iff A<B unsigned.
  - Shifts: last bit shifted out for 1<=B<=WIDTH. 0 for B=0. For B>WIDTH: 0 for LSR/LSL, A[WIDTH-1] for ASR.
  - MUL: 1 iff the upper WIDTH bits of the full product are nonzero.
  - Logic ops and NOT: 0.
- V flag: signed overflow for ADD/SUB only; 0 for all other ops.
- Shift amount is the full unsigned B. For B>=WIDTH, LSR/LSL give 0 and ASR gives all copies of A's sign bit.
- MUL internals: multiplicand A and multiplier B are registered at accept. Accumulator is 2*WIDTH bits. o_result/o_flags update only on entry to DONE; during MUL they hold the previous values with o_valid=0.
- i_valid while not o_ready is ignored; no request is queued.

Test Plan:
- Reset mid-MUL: issue MUL 7*6, assert i_reset low at cycle 5 -> o_valid=0, result=0, flags=0, o_ready=1 after release; the next ADD 1+1 -> 2 in 1 cycle.
- ADD 0xFFFFFFFF+1 -> result 0, flags Z=1 C=1 V=0. ADD 0x7FFFFFFF+1 -> 0x80000000, N=1 V=1 C=0.
- SUB 3-5 -> 0xFFFFFFFE, N=1 C=1. LSR 0x80000001 by 1 -> 0x40000000, C=1. ASR 0x80000000 by 40 -> 0xFFFFFFFF, C=1.
- MUL 0x10000*0x10000 (WIDTH=32) -> result 0, Z=1 C=1, o_valid exactly 33 cycles after accept, o_busy high 32 cycles.
- Backpressure: AND 0xF0F0&0xFF00 with i_out_ready=0 for 4 cycles -> 0xF000 held, o_ready=0; then raise i_out_ready with XOR queued -> back-to-back accept, next result on the following cycle.
- Illegal op 17 -> result 0, ERR=1, Z=1. With MUL_EN=0, op 9 -> ERR=1 in 1 cycle.
